// File: rtl/neuron_post_proc.sv
// Post-processing for MAC accumulators: bias add, optional ReLU, Q8.8 saturation,
// an output FIFO tagged with neuron index, and a running per-layer argmax.
module neuron_post_proc #(
    parameter int NUM_NEURONS = 10,
    parameter int FIFO_DEPTH  = 4,
    parameter int RELU_EN     = 1,
    localparam int IDXW       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   acc_valid,
    output logic                   acc_ready,
    input  logic signed [39:0]     acc_data,
    input  logic                   acc_last,
    input  logic signed [15:0]     bias,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [15:0]     out_data,
    output logic [IDXW-1:0]        out_idx,
    output logic                   cls_valid,
    output logic [IDXW-1:0]        cls_idx,
    output logic signed [15:0]     cls_score,
    output logic                   layer_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // ReLU (if enabled) then clamp the 41-bit sum to the Q8.8 range.
    function automatic logic signed [15:0] relu_sat(input logic signed [40:0] s);
        logic signed [40:0] v;
        v = s;
        if (RELU_EN != 0 && s < 0)
            v = '0;
        if (v > 41'sd32767)
            return 16'sh7FFF;
        else if (v < -41'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    // Stage p0: accept-cycle arithmetic, feeds FIFO and argmax at the same edge
    logic signed [40:0] sum_p0;
    logic signed [15:0] sat_p0;
    logic               vld_p0;
    logic               push, pop;
    logic [PW:0]        count;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [IDXW-1:0]    idx_q;
    logic               idx_wrap;
    logic               max_vld;
    logic signed [15:0] max_val;
    logic [IDXW-1:0]    max_idx;
    logic               take_p0;
    logic signed [15:0] best_val_p0;
    logic [IDXW-1:0]    best_idx_p0;

    logic signed [15:0] data_mem [FIFO_DEPTH];
    logic [IDXW-1:0]    idx_mem  [FIFO_DEPTH];

    assign sum_p0    = $signed({acc_data[39], acc_data}) + $signed({{25{bias[15]}}, bias});
    assign sat_p0    = relu_sat(sum_p0);
    assign acc_ready = (count != (PW+1)'(FIFO_DEPTH));
    assign vld_p0    = acc_valid & acc_ready;
    assign out_valid = (count != '0);
    assign push      = vld_p0;
    assign pop       = out_valid & out_ready;
    assign idx_wrap  = (idx_q == IDXW'(NUM_NEURONS - 1));

    // Ties keep the earlier (lower) index because only a strict win replaces.
    assign take_p0     = !max_vld || (sat_p0 > max_val);
    assign best_val_p0 = take_p0 ? sat_p0 : max_val;
    assign best_idx_p0 = take_p0 ? idx_q  : max_idx;

    assign out_data = out_valid ? data_mem[rd_ptr] : '0;
    assign out_idx  = out_valid ? idx_mem[rd_ptr]  : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= sat_p0;
            idx_mem[wr_ptr]  <= idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Stage p1: index tagging, argmax tracking and class result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            layer_err <= 1'b0;
            max_vld   <= 1'b0;
            cls_valid <= 1'b0;
            cls_idx   <= '0;
            cls_score <= '0;
        end else begin
            cls_valid <= 1'b0;
            if (vld_p0) begin
                idx_q <= (acc_last || idx_wrap) ? '0 : idx_q + IDXW'(1);
                if (idx_wrap && !acc_last)
                    layer_err <= 1'b1;
                if (acc_last) begin
                    cls_valid <= 1'b1;
                    cls_idx   <= best_idx_p0;
                    cls_score <= best_val_p0;
                    max_vld   <= 1'b0;
                end else begin
                    max_vld <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            max_val <= best_val_p0;
            max_idx <= best_idx_p0;
        end
    end

endmodule

// File: tb/tb_neuron_post_proc.sv
// Directed bench for neuron_post_proc: one instance with ReLU and one without,
// sharing the same stimulus.
module tb_neuron_post_proc;

    localparam int IDXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acc_valid = 1'b0;
    logic [39:0] acc_data = '0;
    logic        acc_last = 1'b0;
    logic [15:0] bias = '0;
    logic        out_ready = 1'b1;

    logic            acc_ready, out_valid, cls_valid, layer_err;
    logic [15:0]     out_data, cls_score;
    logic [IDXW-1:0] out_idx, cls_idx;

    logic            acc_ready0, out_valid0, cls_valid0, layer_err0;
    logic [15:0]     out_data0, cls_score0;
    logic [IDXW-1:0] out_idx0, cls_idx0;

    int errors = 0;
    int checks = 0;

    neuron_post_proc #(.NUM_NEURONS(10), .FIFO_DEPTH(4), .RELU_EN(1)) dut (
        .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_data(acc_data), .acc_last(acc_last), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .cls_valid(cls_valid), .cls_idx(cls_idx),
        .cls_score(cls_score), .layer_err(layer_err)
    );

    neuron_post_proc #(.NUM_NEURONS(10), .FIFO_DEPTH(4), .RELU_EN(0)) dut0 (
        .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_ready(acc_ready0),
        .acc_data(acc_data), .acc_last(acc_last), .bias(bias),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_idx(out_idx0), .cls_valid(cls_valid0), .cls_idx(cls_idx0),
        .cls_score(cls_score0), .layer_err(layer_err0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [39:0] acc;
        logic [15:0] bias;
        logic [15:0] exp_relu;
        logic [15:0] exp_lin;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        acc_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [39:0] a, input logic [15:0] b, input logic last);
        acc_valid = 1'b1;
        acc_data  = a;
        bias      = b;
        acc_last  = last;
        step();
    endtask

    logic [15:0] lv [10];
    logic [15:0] ev;

    initial begin
        vt[0]  = '{40'h0000000280, 16'h0100, 16'h0380, 16'h0380};
        vt[1]  = '{40'hFFFFFFFE00, 16'h0080, 16'h0000, 16'hFE80};
        vt[2]  = '{40'h0001000000, 16'h0000, 16'h7FFF, 16'h7FFF};
        vt[3]  = '{40'hFF00000000, 16'h0000, 16'h0000, 16'h8000};
        vt[4]  = '{40'h0000007F00, 16'h00FF, 16'h7FFF, 16'h7FFF};
        vt[5]  = '{40'h0000007F00, 16'h0100, 16'h7FFF, 16'h7FFF};
        vt[6]  = '{40'hFFFFFF8000, 16'h0000, 16'h0000, 16'h8000};
        vt[7]  = '{40'hFFFFFF8000, 16'hFFFF, 16'h0000, 16'h8000};
        vt[8]  = '{40'h7FFFFFFFFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vt[9]  = '{40'h8000000000, 16'h8000, 16'h0000, 16'h8000};
        vt[10] = '{40'h0000000000, 16'hFF00, 16'h0000, 16'hFF00};
        vt[11] = '{40'hFFFFFFFF01, 16'h0100, 16'h0001, 16'h0001};

        lv = '{16'h0100, 16'h0200, 16'h0080, 16'h0500, 16'h0300,
               16'hFF00, 16'h0400, 16'h0500, 16'h0010, 16'h04FF};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_acc_ready", acc_ready, 1);
        chk("rst_cls_valid", cls_valid, 0);
        chk("rst_cls_idx", cls_idx, 0);
        chk("rst_cls_score", cls_score, 0);
        chk("rst_layer_err", layer_err, 0);

        // Single-neuron layers: datapath plus argmax of one element.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push(vt[i].acc, vt[i].bias, 1'b1);
            acc_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_data_relu", i), out_data, vt[i].exp_relu);
            chk($sformatf("v%0d_data_lin", i), out_data0, vt[i].exp_lin);
            chk($sformatf("v%0d_out_idx", i), out_idx, 0);
            chk($sformatf("v%0d_cls_valid", i), cls_valid, 1);
            chk($sformatf("v%0d_cls_score_relu", i), cls_score, vt[i].exp_relu);
            chk($sformatf("v%0d_cls_score_lin", i), cls_score0, vt[i].exp_lin);
            chk($sformatf("v%0d_cls_idx", i), cls_idx, 0);
            step();
            chk($sformatf("v%0d_drained", i), out_valid, 0);
            chk($sformatf("v%0d_cls_pulse_end", i), cls_valid, 0);
        end

        // FIFO fill with consumer stalled.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fill%0d_acc_ready", k), acc_ready, 1);
            push(40'h100 * (k + 1), 16'h0000, 1'b0);
        end
        chk("full_acc_ready", acc_ready, 0);
        acc_valid = 1'b1;
        acc_data  = 40'h500;
        bias      = 16'h0000;
        repeat (2) begin
            step();
            chk("stall_acc_ready", acc_ready, 0);
            chk("stall_head_data", out_data, 16'h0100);
            chk("stall_head_idx", out_idx, 0);
        end
        // Pop and offered push in the same cycle: full flag is registered, so no push.
        out_ready = 1'b1;
        step();
        acc_valid = 1'b0;
        chk("pop_no_push_head", out_idx, 1);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("pop%0d_valid", k), out_valid, 1);
            chk($sformatf("pop%0d_data", k), out_data, 16'h0100 * (k + 1));
            chk($sformatf("pop%0d_idx", k), out_idx, k);
            step();
        end
        chk("pop_empty", out_valid, 0);
        chk("pop_ready_again", acc_ready, 1);

        // Full layer of 10 with tie at idx 3 and 7.
        pulse_rst();
        for (int k = 0; k < 10; k++) begin
            push({{24{lv[k][15]}}, lv[k]}, 16'h0000, k == 9);
            ev = lv[k][15] ? 16'h0000 : lv[k];
            chk($sformatf("L%0d_out_valid", k), out_valid, 1);
            chk($sformatf("L%0d_out_idx", k), out_idx, k);
            chk($sformatf("L%0d_out_data", k), out_data, ev);
            chk($sformatf("L%0d_cls_valid", k), cls_valid, (k == 9) ? 1 : 0);
        end
        acc_valid = 1'b0;
        acc_last  = 1'b0;
        chk("L_cls_idx", cls_idx, 3);
        chk("L_cls_score", cls_score, 16'h0500);
        chk("L_cls_idx_lin", cls_idx0, 3);
        chk("L_cls_score_lin", cls_score0, 16'h0500);
        step();
        chk("L_cls_pulse_end", cls_valid, 0);
        chk("L_cls_idx_hold", cls_idx, 3);
        chk("L_cls_score_hold", cls_score, 16'h0500);
        chk("L_layer_err", layer_err, 0);

        // Mid-layer reset, then a layer that wraps without acc_last.
        for (int k = 0; k < 5; k++)
            push(40'h700, 16'h0000, 1'b0);
        pulse_rst();
        chk("mr_out_valid", out_valid, 0);
        chk("mr_cls_valid", cls_valid, 0);
        chk("mr_cls_idx", cls_idx, 0);
        chk("mr_cls_score", cls_score, 0);
        for (int k = 0; k < 10; k++) begin
            push(40'h100, 16'h0000, 1'b0);
            chk($sformatf("W%0d_out_idx", k), out_idx, k);
            chk($sformatf("W%0d_cls_valid", k), cls_valid, 0);
            chk($sformatf("W%0d_layer_err", k), layer_err, (k == 9) ? 1 : 0);
        end
        acc_valid = 1'b0;
        repeat (2) step();
        chk("W_err_sticky", layer_err, 1);
        chk("W_err_sticky_lin", layer_err0, 1);
        push(40'h200, 16'h0000, 1'b0);
        acc_valid = 1'b0;
        chk("W_idx_wrapped", out_idx, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
